// File: rtl/palette_pkg.sv
// Shared palette types, the reset-time default palette and bank-swap FSM states.
// Pure declarations: no latency, no flow control.
package palette_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEFAULT_PAL_LEN = 8;
  localparam int TRANSPARENT_IDX = 0;

  localparam rgb_t DEFAULT_PAL [DEFAULT_PAL_LEN] = '{
    rgb_t'(24'h000000), rgb_t'(24'h000000), rgb_t'(24'heaf4f8), rgb_t'(24'hc25202),
    rgb_t'(24'hdabe3d), rgb_t'(24'h8b8b32), rgb_t'(24'h284e24), rgb_t'(24'h425b64)
  };

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  // Entries beyond the default table come up black.
  function automatic rgb_t default_rgb(input int idx);
    if (idx >= 0 && idx < DEFAULT_PAL_LEN) return DEFAULT_PAL[idx[2:0]];
    return '0;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Banked palette store: one sync read port (1-cycle), one write port, read-before-write.
// Reset reloads every entry from the default palette in a single cycle; no backpressure.
module palette_ram
  import palette_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int NUM_PAL = 4,
  parameter int COLOR_W = 8,
  localparam int PAL_W  = $clog2(NUM_PAL),
  localparam int AW     = 1 + PAL_W + IDX_W,
  localparam int DW     = 3 * COLOR_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_dat_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_dat_i
);

  // Address is {bank, pal, idx}; rounding up to a power of two keeps decode trivial.
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_dat_q;

  // MSB-align the 8-bit default channel into COLOR_W bits.
  function automatic logic [COLOR_W-1:0] scale(input logic [7:0] c);
    logic [COLOR_W+7:0] ext;
    ext = {c, {COLOR_W{1'b0}}};
    return ext[COLOR_W+7 -: COLOR_W];
  endfunction

  function automatic logic [DW-1:0] init_word(input int e);
    rgb_t d;
    d = default_rgb(e % (2 ** IDX_W));
    return {scale(d.r), scale(d.g), scale(d.b)};
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < DEPTH; e++) mem_q[AW'(e)] <= init_word(e);
      rd_dat_q <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/sprite_palette_lut.sv
// Sprite palette lookup: {pal, idx} -> registered RGB + transparent, 2-cycle latency, 1 pixel/cycle, no backpressure.
// Bank swaps wait for frame_start; `define PALETTE_FLASH_EN adds a frame-counted white flash.
module sprite_palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int NUM_PAL = 4,
  parameter int COLOR_W = 8,
  localparam int PAL_W  = $clog2(NUM_PAL)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 pix_valid_in,
  input  logic [PAL_W-1:0]     pal_sel_in,
  input  logic [IDX_W-1:0]     idx_in,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [PAL_W-1:0]     wr_pal,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [3*COLOR_W-1:0] wr_rgb,
  input  logic                 bank_req,
`ifdef PALETTE_FLASH_EN
  input  logic                 flash_req,
  input  logic [3:0]           flash_frames,
`endif
  output logic                 pix_valid_out,
  output logic [COLOR_W-1:0]   Red,
  output logic [COLOR_W-1:0]   Green,
  output logic [COLOR_W-1:0]   Blue,
  output logic                 transparent,
  output logic                 active_bank
);

  swap_state_t          swap_state_q;
  logic                 bank_q;
  logic                 s1_vld_q;
  logic                 s1_trans_q;
  logic [3*COLOR_W-1:0] rd_dat;
  logic                 flash_on;
  logic                 vld_q;
  logic                 trans_q;
  logic [COLOR_W-1:0]   red_q;
  logic [COLOR_W-1:0]   green_q;
  logic [COLOR_W-1:0]   blue_q;

  // The RAM read register is stage 1, so a same-cycle write is seen by the next read only.
  palette_ram #(
    .IDX_W   (IDX_W),
    .NUM_PAL (NUM_PAL),
    .COLOR_W (COLOR_W)
  ) u_ram (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .rd_addr_i ({bank_q, pal_sel_in, idx_in}),
    .rd_dat_o  (rd_dat),
    .wr_en_i   (wr_en),
    .wr_addr_i ({wr_bank, wr_pal, wr_idx}),
    .wr_dat_i  (wr_rgb)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      swap_state_q <= SWAP_IDLE;
      bank_q       <= 1'b0;
    end else begin
      case (swap_state_q)
        SWAP_IDLE: begin
          if (bank_req) swap_state_q <= SWAP_PENDING;
        end
        SWAP_PENDING: begin
          if (frame_start) begin
            swap_state_q <= SWAP_IDLE;
            bank_q       <= ~bank_q;
          end
        end
        default: swap_state_q <= SWAP_IDLE;
      endcase
    end
  end

`ifdef PALETTE_FLASH_EN
  logic [3:0] flash_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      flash_cnt_q <= '0;
    end else if (flash_req) begin
      flash_cnt_q <= flash_frames;
    end else if (frame_start && flash_cnt_q != '0) begin
      flash_cnt_q <= flash_cnt_q - 4'd1;
    end
  end

  assign flash_on = (flash_cnt_q != '0);
`else
  assign flash_on = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld_q   <= 1'b0;
      s1_trans_q <= 1'b0;
      vld_q      <= 1'b0;
      trans_q    <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      s1_vld_q   <= pix_valid_in;
      s1_trans_q <= (idx_in == IDX_W'(TRANSPARENT_IDX));
      vld_q      <= s1_vld_q;
      trans_q    <= s1_vld_q & s1_trans_q;
      if (!s1_vld_q || s1_trans_q) begin
        {red_q, green_q, blue_q} <= '0;
      end else if (flash_on) begin
        {red_q, green_q, blue_q} <= '1;
      end else begin
        {red_q, green_q, blue_q} <= rd_dat;
      end
    end
  end

  assign pix_valid_out = vld_q;
  assign transparent   = trans_q;
  assign Red           = red_q;
  assign Green         = green_q;
  assign Blue          = blue_q;
  assign active_bank   = bank_q;

endmodule
